// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch-control state encoding
package cpu_pkg;

    localparam logic [31:0] RESET_VEC_DEF  = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF    = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT_DEF = 32'h0000_6FFC;

    // PEND means a redirect arrived during a stall and is waiting for en.
    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_PEND = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_addr_check.sv
// rtl/pc_addr_check.sv - word-alignment and window check for an address
module pc_addr_check #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] BASE  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] LIMIT = 32'h0000_6FFC
) (
    input  logic [WIDTH-1:0] pc,
    output logic             adel
);

    assign adel = (pc[1:0] != 2'b00) || (pc < BASE) || (pc > LIMIT);

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program counter with exception, eret and stall-buffered redirect
module pc_ctrl
    import cpu_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = RESET_VEC_DEF,
    parameter logic [WIDTH-1:0] EXC_VEC    = EXC_VEC_DEF,
    parameter logic [WIDTH-1:0] IMEM_BASE  = IMEM_BASE_DEF,
    parameter logic [WIDTH-1:0] IMEM_LIMIT = IMEM_LIMIT_DEF,
    parameter int               STEP       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic             adel,
    output logic             redir_pending
);

    pc_state_t        state, state_next;
    logic [WIDTH-1:0] pc_q, pc_next;
    logic [WIDTH-1:0] pend_q, pend_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= PC_RUN;
            pc_q   <= RESET_VEC;
            pend_q <= '0;
        end else begin
            state  <= state_next;
            pc_q   <= pc_next;
            pend_q <= pend_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        pend_next  = pend_q;
        if (exc_req) begin
            pc_next    = EXC_VEC;
            pend_next  = '0;
            state_next = PC_RUN;
        end else if (eret_req) begin
            pc_next    = epc;
            pend_next  = '0;
            state_next = PC_RUN;
        end else if (en) begin
            // A live redirect wins over a buffered one; otherwise drain the buffer before stepping.
            if (redir_valid)
                pc_next = redir_target;
            else if (state == PC_PEND)
                pc_next = pend_q;
            else
                pc_next = pc_q + WIDTH'(STEP);
            state_next = PC_RUN;
        end else if (redir_valid) begin
            pend_next  = redir_target;
            state_next = PC_PEND;
        end
    end

    assign pc            = pc_q;
    assign redir_pending = (state == PC_PEND);

    pc_addr_check #(
        .WIDTH (WIDTH),
        .BASE  (IMEM_BASE),
        .LIMIT (IMEM_LIMIT)
    ) u_addr_check (
        .pc   (pc_q),
        .adel (adel)
    );

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - directed and randomized checks of pc_ctrl against a reference model
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = '0;

    logic [31:0] pc_d, pc_w;
    logic        adel_d, adel_w, pend_d, pend_w;

    int checks = 0;
    int failures = 0;

    // index 0: default instance, index 1: instance whose reset vector sits at the top of memory
    logic [31:0] rv   [2];
    logic [31:0] m_pc [2];
    logic        m_pv [2];
    logic [31:0] m_pt [2];

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .redir_valid(redir_valid),
        .redir_target(redir_target), .exc_req(exc_req), .eret_req(eret_req),
        .epc(epc), .pc(pc_d), .adel(adel_d), .redir_pending(pend_d)
    );

    pc_ctrl #(.RESET_VEC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .en(en), .redir_valid(redir_valid),
        .redir_target(redir_target), .exc_req(exc_req), .eret_req(eret_req),
        .epc(epc), .pc(pc_w), .adel(adel_w), .redir_pending(pend_w)
    );

    function automatic logic exp_adel(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_pc[i] = rv[i]; m_pv[i] = 1'b0; m_pt[i] = '0;
            end else if (exc_req) begin
                m_pc[i] = 32'h4180; m_pv[i] = 1'b0;
            end else if (eret_req) begin
                m_pc[i] = epc; m_pv[i] = 1'b0;
            end else if (en) begin
                if (redir_valid)  m_pc[i] = redir_target;
                else if (m_pv[i]) m_pc[i] = m_pt[i];
                else              m_pc[i] = m_pc[i] + 32'd4;
                m_pv[i] = 1'b0;
            end else if (redir_valid) begin
                m_pv[i] = 1'b1; m_pt[i] = redir_target;
            end
        end
    endtask

    task automatic check_model();
        check("pc_model",     pc_d,          m_pc[0]);
        check("adel_model",   {31'b0, adel_d}, {31'b0, exp_adel(m_pc[0])});
        check("pend_model",   {31'b0, pend_d}, {31'b0, m_pv[0]});
        check("pc_w_model",   pc_w,          m_pc[1]);
        check("adel_w_model", {31'b0, adel_w}, {31'b0, exp_adel(m_pc[1])});
        check("pend_w_model", {31'b0, pend_w}, {31'b0, m_pv[1]});
    endtask

    task automatic step(input logic r, input logic e, input logic rv_i, input logic [31:0] tgt,
                        input logic x, input logic er, input logic [31:0] ep);
        reset = r; en = e; redir_valid = rv_i; redir_target = tgt;
        exc_req = x; eret_req = er; epc = ep;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0: a = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
            1: a = $urandom & 32'hFFFF_FFFC;
            2: a = 32'h3000 + $urandom_range(0, 32'h3FFF);
            default: begin
                case ($urandom_range(0, 3))
                    0: a = 32'h2FFC;
                    1: a = 32'h3000;
                    2: a = 32'h6FFC;
                    default: a = 32'h7000;
                endcase
            end
        endcase
        return a;
    endfunction

    initial begin
        rv[0] = 32'h0000_3000;
        rv[1] = 32'hFFFF_FFFC;

        // reset state
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_pc", pc_d, 32'h3000);
        check("rst_adel", {31'b0, adel_d}, 32'd0);
        check("rst_pend", {31'b0, pend_d}, 32'd0);
        check("rst_pc_w", pc_w, 32'hFFFF_FFFC);

        // sequential fetch and wrap
        step(0, 1, 0, 0, 0, 0, 0);
        check("seq1", pc_d, 32'h3004);
        check("wrap", pc_w, 32'h0000_0000);
        step(0, 1, 0, 0, 0, 0, 0);
        check("seq2", pc_d, 32'h3008);
        step(0, 1, 0, 0, 0, 0, 0);
        check("seq3", pc_d, 32'h300C);
        check("seq3_adel", {31'b0, adel_d}, 32'd0);

        // redirect buffered through a stall
        step(0, 0, 1, 32'h3100, 0, 0, 0);
        check("stall_hold", pc_d, 32'h300C);
        check("stall_pend", {31'b0, pend_d}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("stall_hold2", pc_d, 32'h300C);
        check("stall_pend2", {31'b0, pend_d}, 32'd1);
        step(0, 1, 0, 0, 0, 0, 0);
        check("pend_drain", pc_d, 32'h3100);
        check("pend_clear", {31'b0, pend_d}, 32'd0);

        // newer pending redirect overwrites older
        step(0, 0, 1, 32'h3100, 0, 0, 0);
        step(0, 0, 1, 32'h3200, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("pend_overwrite", pc_d, 32'h3200);

        // exception from PEND, then eret
        step(0, 0, 1, 32'h3300, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("exc_pc", pc_d, 32'h4180);
        check("exc_pend", {31'b0, pend_d}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 32'h3010);
        check("eret_pc", pc_d, 32'h3010);

        // address-error boundaries
        step(0, 1, 1, 32'h3002, 0, 0, 0);
        check("adel_misalign", {31'b0, adel_d}, 32'd1);
        step(0, 1, 1, 32'h7000, 0, 0, 0);
        check("adel_above", {31'b0, adel_d}, 32'd1);
        step(0, 1, 1, 32'h6FFC, 0, 0, 0);
        check("adel_limit", {31'b0, adel_d}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("adel_step_out", {31'b0, adel_d}, 32'd1);
        check("step_out_pc", pc_d, 32'h7000);

        // reset while pending discards the buffered redirect
        step(0, 0, 1, 32'h3400, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_pend_pc", pc_d, 32'h3000);
        check("rst_pend_flag", {31'b0, pend_d}, 32'd0);
        check("rst_pend_pc_w", pc_w, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0, 0, 0);
        check("rst_pend_after", pc_d, 32'h3004);

        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 3),
                 rand_addr(),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 19) == 0),
                 rand_addr());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
